freq_div_sched: RTL and testbench
=================================

# freq_div_sched

Runtime-programmable scheduler for the clock-divider waveform datapath. It holds the active period/on-time configuration and accepts new settings over a valid/ready port. New settings take effect only at a period boundary, so the output never glitches. It sequences start, stop and fixed-length bursts of divided periods, and sits between the control/register logic and any consumer of the divided waveform.

## Interface
- CNT_W, 16, width of period/on-time fields and internal cycle counter
- BURST_W, 8, width of burst-length field and remaining-period counter
- DEF_PERIOD, 6, active period after reset (cycles)
- DEF_ON, 3, active on-time after reset (cycles)

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cfg_valid  in  1  configuration offer
- cfg_ready  out  1  scheduler can accept configuration
- cfg_period  in  CNT_W  requested period in cycles
- cfg_on  in  CNT_W  requested high cycles per period
- cfg_burst  in  BURST_W  periods per run; 0 = continuous
- start  in  1  begin a run (level sampled each cycle)
- stop  in  1  request graceful end of run
- out_wave  out  1  divided waveform, registered
- busy  out  1  run in progress (RUN or DRAIN)
- done  out  1  one-cycle pulse when a run ends
- cfg_err  out  1  one-cycle pulse when an accepted configuration is rejected

## Operation
- Reset values:
  - out_wave=0, busy=0, done=0, cfg_err=0, cfg_ready=1, state=IDLE, counter=0.
  - Active config = {DEF_PERIOD, DEF_ON, burst 0}. No pending shadow config.
- Waveform in RUN/DRAIN:
  - counter runs 0..period-1 and then wraps to 0.
  - out_wave=1 while counter<on, else 0.
- Config validity:
  - Valid means period>=2, 1<=on<=period-1.
  - Comparisons are unsigned at CNT_W.
  - Burst has no restriction.
- Handshake:
  - Transfer occurs when cfg_valid && cfg_ready.
  - A valid config goes to the shadow register, and cfg_ready drops to 0 until the shadow is applied.
  - An invalid config is discarded. cfg_err pulses the next cycle, cfg_ready stays 1 and the active config is unchanged.
- Applying the shadow config:
  - In IDLE: shadow is copied to active on the cycle after the handshake, and cfg_ready returns to 1 that cycle.
  - In RUN/DRAIN: shadow is copied at the wrap, i.e. the first cycle of the next period uses the new values. cfg_ready returns to 1 the same cycle.
- A new cfg_burst applied mid-run does not change the remaining count of the current run. It is used on the next start.
- States:
  - IDLE: out_wave=0, busy=0. On start && !stop: go to RUN, counter=0, remaining=active burst.
    - stop has priority over start in IDLE. start and stop together leave the block in IDLE.
  - RUN, at each period wrap:
    - If burst≠0, decrement remaining. If remaining hits 0, go to IDLE and pulse done.
    - If stop was seen during this period, go to IDLE and pulse done.
    - stop seen mid-period moves RUN to DRAIN immediately; the waveform continues unchanged.
  - DRAIN: finish the current period, then go to IDLE and pulse done. Extra stop/start inputs are ignored.
- start is ignored in RUN/DRAIN.
- No partial periods are ever emitted except when reset is asserted.
- Reset mid-run: the next cycle shows all outputs at reset values, and any pending shadow config is lost.

## Timing
- start sampled high at cycle t (IDLE) gives:
  - out_wave=1 and busy=1 at t+1.
  - out_wave high during t+1..t+on, low during t+on+1..t+period.
  - Next period starts at t+period+1.
- Final period ending at cycle e (counter=period-1) gives:
  - state=IDLE, busy=0, done=1 and out_wave=0 at e+1.
  - done=0 at e+2.
- A start held high at e+1 launches the next run at e+2. There is a minimum 1-cycle low gap between runs.
- A config handshake at cycle h while in RUN, with the current period ending at e≥h, makes the new values effective from e+1.
  - If h coincides with the last counter value, the new values are still effective from e+1.
- cfg_err goes high at h+1 only.
- Handshake and wrap in the same cycle: the old shadow (if any) is impossible, because cfg_ready=0 while one is pending.

## Test plan
- Reset defaults, start for 1 cycle, cfg_burst=0 -> out_wave pattern 111000 repeating from the cycle after start; busy=1; done never pulses.
- Config {period 4, on 1, burst 3} in IDLE, then start -> exactly three 1000 periods, then done pulses once, busy=0, out_wave=0.
- Continuous run at {6,3}; cfg {10,7} offered at counter=2 -> current period completes as 111000, next periods are 1111111000; cfg_ready=0 from handshake until that boundary.
- Invalid cfgs {1,0}, {5,5} and {5,0} -> cfg_err pulses 1 cycle each; active config unchanged; cfg_ready stays 1.
- stop asserted at counter=1 of a {6,3} run -> period finishes (111000), done at next cycle; start+stop together in IDLE -> stays IDLE.
- reset asserted at counter=2 with a pending shadow -> all outputs at reset values next cycle; next start runs DEF_PERIOD/DEF_ON.

Source files
------------

// File: rtl/freq_div_sched.sv
// Runtime-programmable clock-divider scheduler: glitch-free period/on-time
// reconfiguration at period boundaries, with start, graceful stop and bursts.
module freq_div_sched #(
    parameter int CNT_W      = 16,
    parameter int BURST_W    = 8,
    parameter int DEF_PERIOD = 6,
    parameter int DEF_ON     = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [CNT_W-1:0]   cfg_on,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               start,
    input  logic               stop,
    output logic               out_wave,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state, nxt_state;
    logic [CNT_W-1:0]   cnt, nxt_cnt;
    logic [CNT_W-1:0]   act_period, nxt_act_period;
    logic [CNT_W-1:0]   act_on, nxt_act_on;
    logic [BURST_W-1:0] act_burst, nxt_act_burst;
    logic [CNT_W-1:0]   sh_period, nxt_sh_period;
    logic [CNT_W-1:0]   sh_on, nxt_sh_on;
    logic [BURST_W-1:0] sh_burst, nxt_sh_burst;
    logic               pend, nxt_pend;
    logic [BURST_W-1:0] remaining, nxt_remaining;
    logic               nxt_out, nxt_done, nxt_err;
    logic               hs, cfg_ok, running, wrap;

    assign cfg_ready = !pend;
    assign busy      = (state != IDLE);

    // Config acceptance, boundary-aligned activation, run sequencing and the
    // registered waveform bit for the next cycle.
    always_comb begin
        nxt_state      = state;
        nxt_cnt        = cnt;
        nxt_act_period = act_period;
        nxt_act_on     = act_on;
        nxt_act_burst  = act_burst;
        nxt_sh_period  = sh_period;
        nxt_sh_on      = sh_on;
        nxt_sh_burst   = sh_burst;
        nxt_pend       = pend;
        nxt_remaining  = remaining;
        nxt_done       = 1'b0;

        hs      = cfg_valid && !pend;
        cfg_ok  = (cfg_period >= CNT_W'(2)) && (cfg_on != '0) && (cfg_on < cfg_period);
        running = (state != IDLE);
        wrap    = running && (cnt == act_period - CNT_W'(1));
        nxt_err = hs && !cfg_ok;

        // An offer landing exactly on the wrap bypasses the shadow so it still
        // takes effect from the very next period.
        if (pend && (!running || wrap)) begin
            nxt_act_period = sh_period;
            nxt_act_on     = sh_on;
            nxt_act_burst  = sh_burst;
            nxt_pend       = 1'b0;
        end else if (hs && cfg_ok && wrap) begin
            nxt_act_period = cfg_period;
            nxt_act_on     = cfg_on;
            nxt_act_burst  = cfg_burst;
        end else if (hs && cfg_ok) begin
            nxt_sh_period  = cfg_period;
            nxt_sh_on      = cfg_on;
            nxt_sh_burst   = cfg_burst;
            nxt_pend       = 1'b1;
        end

        case (state)
            IDLE: begin
                nxt_cnt = '0;
                if (start && !stop) begin
                    nxt_state     = RUN;
                    nxt_remaining = nxt_act_burst;
                end
            end
            RUN: begin
                if (wrap) begin
                    nxt_cnt = '0;
                    if (stop || remaining == BURST_W'(1)) begin
                        nxt_state = IDLE;
                        nxt_done  = 1'b1;
                    end else if (remaining != '0) begin
                        nxt_remaining = remaining - BURST_W'(1);
                    end
                end else begin
                    nxt_cnt = cnt + CNT_W'(1);
                    if (stop) nxt_state = DRAIN;
                end
            end
            DRAIN: begin
                if (wrap) begin
                    nxt_cnt   = '0;
                    nxt_state = IDLE;
                    nxt_done  = 1'b1;
                end else begin
                    nxt_cnt = cnt + CNT_W'(1);
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_cnt   = '0;
            end
        endcase

        nxt_out = (nxt_state != IDLE) && (nxt_cnt < nxt_act_on);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            act_period <= CNT_W'(DEF_PERIOD);
            act_on     <= CNT_W'(DEF_ON);
            act_burst  <= '0;
            sh_period  <= '0;
            sh_on      <= '0;
            sh_burst   <= '0;
            pend       <= 1'b0;
            remaining  <= '0;
            out_wave   <= 1'b0;
            done       <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            act_period <= nxt_act_period;
            act_on     <= nxt_act_on;
            act_burst  <= nxt_act_burst;
            sh_period  <= nxt_sh_period;
            sh_on      <= nxt_sh_on;
            sh_burst   <= nxt_sh_burst;
            pend       <= nxt_pend;
            remaining  <= nxt_remaining;
            out_wave   <= nxt_out;
            done       <= nxt_done;
            cfg_err    <= nxt_err;
        end
    end

endmodule

// File: tb/tb_freq_div_sched.sv
// Self-checking bench for freq_div_sched: directed scenarios plus randomized
// bursts checked against an arithmetic waveform model.
module tb_freq_div_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_period;
    logic [15:0] cfg_on;
    logic [7:0]  cfg_burst;
    logic        start;
    logic        stop;
    logic        out_wave;
    logic        busy;
    logic        done;
    logic        cfg_err;

    int errors = 0;
    int checks = 0;

    freq_div_sched dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_on     (cfg_on),
        .cfg_burst  (cfg_burst),
        .start      (start),
        .stop       (stop),
        .out_wave   (out_wave),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected waveform bit at position k (cycles since the run's first cycle).
    function automatic logic model_wave(input int k, input int p, input int o);
        return (k % p) < o;
    endfunction

    task automatic offer(input int p, input int o, input int b);
        cfg_valid  = 1'b1;
        cfg_period = 16'(p);
        cfg_on     = 16'(o);
        cfg_burst  = 8'(b);
        tick();
        cfg_valid  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic expect_end(input string tag);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_wave"}, out_wave, 1'b0);
        tick();
        check({tag, "_done_clr"}, done, 1'b0);
    endtask

    initial begin
        int p, o, b;
        reset = 1'b1; cfg_valid = 1'b0; cfg_period = '0; cfg_on = '0;
        cfg_burst = '0; start = 1'b0; stop = 1'b0;
        tick(); tick();
        reset = 1'b0;

        check("rst_wave", out_wave, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", cfg_err, 1'b0);
        check("rst_ready", cfg_ready, 1'b1);

        // Default continuous run, then stop at counter 1.
        pulse_start();
        for (int k = 0; k < 13; k++) begin
            check("def_wave", out_wave, model_wave(k, 6, 3));
            check("def_busy", busy, 1'b1);
            check("def_done", done, 1'b0);
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        for (int c = 2; c < 6; c++) begin
            check("drain_wave", out_wave, model_wave(c, 6, 3));
            check("drain_busy", busy, 1'b1);
            tick();
        end
        expect_end("stop");

        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("startstop_busy", busy, 1'b0);
        check("startstop_wave", out_wave, 1'b0);

        // Invalid configurations.
        offer(1, 0, 0);
        check("inv1_err", cfg_err, 1'b1);
        check("inv1_ready", cfg_ready, 1'b1);
        tick();
        check("inv1_err_clr", cfg_err, 1'b0);
        offer(5, 5, 0);
        check("inv2_err", cfg_err, 1'b1);
        tick();
        check("inv2_err_clr", cfg_err, 1'b0);
        offer(5, 0, 0);
        check("inv3_err", cfg_err, 1'b1);
        check("inv3_ready", cfg_ready, 1'b1);
        tick();

        // Mid-run reconfiguration at counter 2, then at the last counter.
        pulse_start();
        for (int k = 0; k < 2; k++) begin
            check("mid_wave_pre", out_wave, model_wave(k, 6, 3));
            tick();
        end
        check("mid_wave_c2", out_wave, 1'b1);
        offer(10, 7, 0);
        for (int c = 3; c < 6; c++) begin
            check("mid_ready_low", cfg_ready, 1'b0);
            check("mid_wave_old", out_wave, model_wave(c, 6, 3));
            tick();
        end
        check("mid_ready_back", cfg_ready, 1'b1);
        for (int k = 0; k < 19; k++) begin
            check("mid_wave_new", out_wave, model_wave(k, 10, 7));
            tick();
        end
        check("last_wave_c9", out_wave, 1'b0);
        offer(4, 2, 0);
        check("last_ready", cfg_ready, 1'b1);
        for (int k = 0; k < 8; k++) begin
            check("last_wave_new", out_wave, model_wave(k, 4, 2));
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        for (int c = 1; c < 4; c++) begin
            check("last_drain_wave", out_wave, model_wave(c, 4, 2));
            tick();
        end
        expect_end("last_stop");

        // Bursts: first fixed, the rest randomized.
        for (int r = 0; r < 6; r++) begin
            if (r == 0) begin
                p = 4; o = 1; b = 3;
            end else begin
                p = int'($urandom_range(9, 2));
                o = int'($urandom_range(p - 1, 1));
                b = int'($urandom_range(4, 1));
            end
            check("burst_ready_pre", cfg_ready, 1'b1);
            offer(p, o, b);
            check("burst_ready_hs", cfg_ready, 1'b0);
            tick();
            check("burst_ready_applied", cfg_ready, 1'b1);
            pulse_start();
            for (int k = 0; k < b * p; k++) begin
                check("burst_wave", out_wave, model_wave(k, p, o));
                check("burst_busy", busy, 1'b1);
                check("burst_done", done, 1'b0);
                tick();
            end
            expect_end("burst");
        end

        // Reset during a run with a pending shadow config.
        offer(8, 5, 0);
        tick();
        pulse_start();
        tick(); tick();
        offer(3, 1, 0);
        check("pend_ready", cfg_ready, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_wave", out_wave, 1'b0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_done", done, 1'b0);
        check("mrst_err", cfg_err, 1'b0);
        check("mrst_ready", cfg_ready, 1'b1);
        pulse_start();
        for (int k = 0; k < 12; k++) begin
            check("mrst_def_wave", out_wave, model_wave(k, 6, 3));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
